// File: rtl/serial_sample_responder.sv
// serial_sample_responder
// Command/response engine sitting between a UART receiver/transmitter pair and
// a bank of NUM_CH sensor sample sources. A one-byte host command selects one
// channel or all channels; the selected samples are snapshotted and streamed
// back as a framed, little-endian response with a single-start handshake on
// tx_busy. Unknown commands are answered with a single NAK byte.
//
// Optional feature: define SERIAL_RESP_CHECKSUM_EN to append an XOR checksum
// byte to every data frame (never to NAK frames). Without the macro no
// checksum logic exists.

module serial_sample_responder #(
  parameter int         NUM_CH    = 3,
  parameter int         SAMPLE_W  = 16,
  parameter logic [7:0] CMD_BASE  = 8'h78,
  parameter logic [7:0] CMD_ALL   = 8'h61,
  parameter logic [7:0] SYNC_BYTE = 8'h00,
  parameter logic [7:0] NAK_BYTE  = 8'h15
) (
  input  logic                       CLK_50,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [2:0]                 sel_ch,
  output logic                       resp_busy,
  output logic                       cmd_drop
);

  // Bytes per sample, width of one zero-padded sample slot, and of the shadow.
  localparam int NB     = (SAMPLE_W + 7) / 8;
  localparam int SLOT_W = NB * 8;
  localparam int SH_W   = NUM_CH * SLOT_W;

`ifdef SERIAL_RESP_CHECKSUM_EN
  localparam int CSUM_LEN = 1;
`else
  localparam int CSUM_LEN = 0;
`endif

  // Byte index of the last byte in the longest frame, and counter width.
  localparam int MAX_IDX = NUM_CH * NB + CSUM_LEN;
  localparam int CNT_W   = $clog2(MAX_IDX + 1);

  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(NB + CSUM_LEN);
  localparam logic [CNT_W-1:0] LAST_ALL = CNT_W'(NUM_CH * NB + CSUM_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_ACK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_tx_start;
  logic              w_advance;

  logic [7:0]        w_cmd_off;
  logic              w_is_chan;
  logic              w_is_all;

  logic [SH_W-1:0]   w_all_padded;
  logic [SH_W-1:0]   w_one_padded;
  logic [SH_W-1:0]   r_shadow;

  logic [CNT_W-1:0]  r_byte_cnt;
  logic [CNT_W-1:0]  r_last_idx;
  logic              r_all_mode;
  logic              r_nak;
  logic [2:0]        r_sel_ch;
  logic              r_cmd_drop;
  logic [7:0]        w_tx_byte;

`ifdef SERIAL_RESP_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // Command decode; a channel code takes priority over an overlapping CMD_ALL.
  always_comb begin
    w_cmd_off = rx_data - CMD_BASE;
    w_is_chan = (w_cmd_off < 8'(NUM_CH));
    w_is_all  = !w_is_chan && (rx_data == CMD_ALL);
  end

  // Zero-pad every channel into its own byte-aligned slot, channel 0 lowest.
  always_comb begin
    w_all_padded = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_all_padded[i*SLOT_W +: SAMPLE_W] = ch_data[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Single-channel snapshot: the selected slot moved down to the bottom.
  always_comb begin
    w_one_padded = '0;
    w_one_padded[SLOT_W-1:0] = w_all_padded[r_sel_ch*SLOT_W +: SLOT_W];
  end

  // Byte currently offered to the transmitter: header, sample bytes, checksum.
  always_comb begin
    w_tx_byte = r_shadow[7:0];
    if (r_byte_cnt == '0) begin
      w_tx_byte = r_nak ? NAK_BYTE : SYNC_BYTE;
    end
`ifdef SERIAL_RESP_CHECKSUM_EN
    else if (r_byte_cnt == r_last_idx) begin
      w_tx_byte = r_csum;
    end
`endif
  end

  // State register.
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the start strobe and the byte-advance request.
  always_comb begin
    w_next_state = r_state;
    w_tx_start   = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (w_is_chan || w_is_all) begin
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_SEND;
          end
        end
      end
      S_LOAD: begin
        w_next_state = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy && !rst) begin
          w_tx_start   = 1'b1;
          w_next_state = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          if (r_byte_cnt == r_last_idx) begin
            w_next_state = S_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = S_SEND;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Frame bookkeeping: command latch, snapshot, byte counter and drop flag.
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_last_idx <= '0;
      r_all_mode <= 1'b0;
      r_nak      <= 1'b0;
      r_sel_ch   <= 3'd0;
      r_shadow   <= '0;
      r_cmd_drop <= 1'b0;
    end else begin
      r_cmd_drop <= rx_valid && (r_state != S_IDLE);
      if ((r_state == S_IDLE) && rx_valid) begin
        r_byte_cnt <= '0;
        if (w_is_chan) begin
          r_sel_ch   <= w_cmd_off[2:0];
          r_all_mode <= 1'b0;
          r_nak      <= 1'b0;
          r_last_idx <= LAST_ONE;
        end else if (w_is_all) begin
          r_all_mode <= 1'b1;
          r_nak      <= 1'b0;
          r_last_idx <= LAST_ALL;
        end else begin
          r_nak      <= 1'b1;
          r_last_idx <= '0;
        end
      end
      if (r_state == S_LOAD) begin
        r_byte_cnt <= '0;
        r_shadow   <= r_all_mode ? w_all_padded : w_one_padded;
      end
      if (w_advance) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
        if (r_byte_cnt != '0) begin
          r_shadow <= r_shadow >> 8;
        end
      end
    end
  end

`ifdef SERIAL_RESP_CHECKSUM_EN
  // Running XOR of every byte handed to the transmitter in the current frame.
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      r_csum <= 8'h00;
    end else if (r_state == S_LOAD) begin
      r_csum <= 8'h00;
    end else if (w_tx_start) begin
      r_csum <= r_csum ^ w_tx_byte;
    end
  end
`endif

  assign tx_start  = w_tx_start;
  assign tx_data   = (r_state == S_IDLE) ? 8'h00 : w_tx_byte;
  assign sel_ch    = r_sel_ch;
  assign resp_busy = (r_state != S_IDLE);
  assign cmd_drop  = r_cmd_drop;

endmodule
